// File: rtl/seq_pattern_gen_if.sv
// Handshake/stream bundle for seq_pattern_gen: control and pattern inputs plus
// the registered serial output. master = stimulus side, slave = generator.
interface seq_pattern_gen_if #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int REP_W   = 4,
  parameter int GAP_W   = 4
);
  logic               start;
  logic               abort;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   len;
  logic [REP_W-1:0]   reps;
  logic [GAP_W-1:0]   gap;
  logic               out;
  logic               out_valid;
  logic               busy;
  logic               done;

  modport master (
    output start, abort, pattern, len, reps, gap,
    input  out, out_valid, busy, done
  );

  modport slave (
    input  start, abort, pattern, len, reps, gap,
    output out, out_valid, busy, done
  );
endinterface

// File: rtl/seq_pattern_gen.sv
// Serial bit-pattern transmitter: shifts a latched pattern out MSB-first,
// repeated a programmable number of times with an optional idle gap between.
module seq_pattern_gen #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int REP_W   = 4,
  parameter int GAP_W   = 4
) (
  input logic              clk,
  input logic              rst,
  seq_pattern_gen_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  state_t             state;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   bit_idx;
  logic [REP_W-1:0]   rep_cnt;
  logic [GAP_W-1:0]   gap_q;
  logic [GAP_W-1:0]   gap_cnt;

  logic [LEN_W-1:0]   len_eff;
  logic [REP_W-1:0]   reps_eff;

  always_comb begin
    len_eff  = (bus.len > MAX_LEN_L) ? MAX_LEN_L : bus.len;
    reps_eff = (bus.reps == '0) ? REP_W'(1) : bus.reps;
  end

  // Shift rather than index so the bit select stays width-clean for any LEN_W.
  function automatic logic pick(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] idx);
    logic [MAX_LEN-1:0] s;
    s = p >> idx;
    return s[0];
  endfunction

  // NOTE: every register here uses <= so all state updates see pre-edge values;
  // blocking assignments in a clocked block create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      pat_q         <= '0;
      len_q         <= '0;
      bit_idx       <= '0;
      rep_cnt       <= '0;
      gap_q         <= '0;
      gap_cnt       <= '0;
      bus.out       <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
    end else if (bus.abort) begin
      state         <= IDLE;
      bus.out       <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start && bus.len != '0) begin
            pat_q         <= bus.pattern;
            len_q         <= len_eff;
            rep_cnt       <= reps_eff;
            gap_q         <= bus.gap;
            bit_idx       <= len_eff - 1'b1;
            bus.out       <= pick(bus.pattern, len_eff - 1'b1);
            bus.out_valid <= 1'b1;
            bus.busy      <= 1'b1;
            state         <= SHIFT;
          end
        end
        SHIFT: begin
          if (bit_idx != '0) begin
            bit_idx <= bit_idx - 1'b1;
            bus.out <= pick(pat_q, bit_idx - 1'b1);
          end else if (rep_cnt == REP_W'(1)) begin
            rep_cnt       <= '0;
            bus.out       <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b1;
            state         <= DONE;
          end else begin
            rep_cnt <= rep_cnt - 1'b1;
            if (gap_q == '0) begin
              bit_idx <= len_q - 1'b1;
              bus.out <= pick(pat_q, len_q - 1'b1);
            end else begin
              gap_cnt       <= gap_q - 1'b1;
              bus.out       <= 1'b0;
              bus.out_valid <= 1'b0;
              state         <= GAP;
            end
          end
        end
        GAP: begin
          // gap_cnt was preloaded with gap-1, so this state lasts exactly gap cycles.
          if (gap_cnt == '0) begin
            bit_idx       <= len_q - 1'b1;
            bus.out       <= pick(pat_q, len_q - 1'b1);
            bus.out_valid <= 1'b1;
            state         <= SHIFT;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
